// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the E-stage issue logic and the
// multiply/divide unit that owns HI/LO.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit holding architectural HI/LO.
// The result is computed on the accepting edge and retired after a fixed busy period.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    mul_div_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_p1, pend_hi_d;
    logic [31:0]        pend_lo_p1, pend_lo_d;
    logic               pend_wr_p1, pend_wr_d;

    // 32x32 -> 64 product; operands are sign- or zero-extended to 64 bits first.
    function automatic logic [63:0] mul_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic is_signed);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = is_signed ? {{32{x[31]}}, x} : {32'd0, x};
        sy = is_signed ? {{32{y[31]}}, y} : {32'd0, y};
        return sx * sy;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so the
    // 0x80000000 / -1 case wraps naturally to quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic is_signed);
        logic        neg_x;
        logic        neg_y;
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        neg_x = is_signed & x[31];
        neg_y = is_signed & y[31];
        mx    = neg_x ? (32'd0 - x) : x;
        my    = neg_y ? (32'd0 - y) : y;
        if (my == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mx / my;
            r = mx % my;
        end
        if (neg_x ^ neg_y) q = 32'd0 - q;
        if (neg_x)         r = 32'd0 - r;
        return {r, q};
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_p1;
        pend_lo_d = pend_lo_p1;
        pend_wr_d = pend_wr_p1;

        case (state_q)
            ST_IDLE: begin
                if (md.start && !md.cancel) begin
                    case (md.op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = mul_op(md.a, md.b, md.op == OP_MULT);
                            pend_wr_d = 1'b1;
                            count_d   = CNT_W'(MUL_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            {pend_hi_d, pend_lo_d} = div_op(md.a, md.b, md.op == OP_DIV);
                            // A zero divisor still occupies the unit but leaves HI/LO alone.
                            pend_wr_d = (md.b != 32'd0);
                            count_d   = CNT_W'(DIV_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_MTHI: hi_d = md.a;
                        OP_MTLO: lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (md.cancel) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        if (pend_wr_p1) begin
                            hi_d = pend_hi_p1;
                            lo_d = pend_lo_p1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_p1 <= 32'd0;
            pend_lo_p1 <= 32'd0;
            pend_wr_p1 <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= (state_d == ST_BUSY);
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_p1 <= pend_hi_d;
            pend_lo_p1 <= pend_lo_d;
            pend_wr_p1 <= pend_wr_d;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: scoreboard of expected {hi,lo} per MD op,
// plus direct checks of MTHI/MTLO, cancel, ignored starts and async reset.
module tb_mul_div_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [63:0] sb[$];

    mul_div_unit_if mdif();

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge after the accepting edge (busy cycle 1).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        mdif.start = 1'b1;
        mdif.op    = o;
        mdif.a     = x;
        mdif.b     = y;
        @(negedge clk);
        mdif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n0, input int exp_cycles);
        int n;
        n = n0;
        while (mdif.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s busy_cycles", tag), 32'(n), 32'(exp_cycles));
    endtask

    task automatic expect_result(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
        end else begin
            e = sb.pop_front();
            check($sformatf("%s hi", tag), mdif.hi, e[63:32]);
            check($sformatf("%s lo", tag), mdif.lo, e[31:0]);
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int cycles,
                          input logic [31:0] ehi, input logic [31:0] elo);
        sb.push_back({ehi, elo});
        issue(o, x, y);
        wait_done(tag, 0, cycles);
        expect_result(tag);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        mdif.start   = 1'b0;
        mdif.op      = 3'd0;
        mdif.a       = 32'd0;
        mdif.b       = 32'd0;
        mdif.cancel  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(mdif.busy), 32'd0);
        check("reset hi", mdif.hi, 32'd0);
        check("reset lo", mdif.lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_md("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

        issue(3'd4, 32'h11, 32'd0);
        check("mthi hi", mdif.hi, 32'h11);
        check("mthi busy", 32'(mdif.busy), 32'd0);
        check("mthi lo kept", mdif.lo, 32'h8000_0000);
        issue(3'd5, 32'h22, 32'd0);
        check("mtlo lo", mdif.lo, 32'h22);
        check("mtlo hi kept", mdif.hi, 32'h11);

        run_md("divu_zero", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_md("divu_7", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Starts presented during busy cycles 1 and 2 must be ignored.
        sb.push_back({32'd0, 32'd42});
        issue(3'd1, 32'd6, 32'd7);
        mdif.start = 1'b1; mdif.op = 3'd4; mdif.a = 32'hDEAD; mdif.b = 32'd0;
        @(negedge clk);
        mdif.op = 3'd0; mdif.a = 32'd1; mdif.b = 32'd1;
        @(negedge clk);
        mdif.start = 1'b0;
        wait_done("busy_ignore", 2, 5);
        expect_result("busy_ignore");

        // Cancel at busy cycle 3.
        issue(3'd0, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        mdif.cancel = 1'b1;
        @(negedge clk);
        mdif.cancel = 1'b0;
        check("cancel busy", 32'(mdif.busy), 32'd0);
        repeat (6) @(negedge clk);
        check("cancel hi", mdif.hi, 32'd0);
        check("cancel lo", mdif.lo, 32'd42);

        issue(3'd4, 32'hABCD, 32'd0);
        check("mthi2 hi", mdif.hi, 32'hABCD);
        check("mthi2 busy", 32'(mdif.busy), 32'd0);

        // Cancel together with a start in IDLE drops the op.
        @(negedge clk);
        mdif.start = 1'b1; mdif.cancel = 1'b1; mdif.op = 3'd5; mdif.a = 32'h55;
        @(negedge clk);
        mdif.op = 3'd0; mdif.a = 32'd9; mdif.b = 32'd9;
        @(negedge clk);
        mdif.start = 1'b0; mdif.cancel = 1'b0;
        check("idle_cancel lo", mdif.lo, 32'd42);
        check("idle_cancel busy", 32'(mdif.busy), 32'd0);

        // Cancel on the completing edge wins.
        issue(3'd0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        mdif.cancel = 1'b1;
        @(negedge clk);
        mdif.cancel = 1'b0;
        check("late_cancel busy", 32'(mdif.busy), 32'd0);
        check("late_cancel hi", mdif.hi, 32'hABCD);
        check("late_cancel lo", mdif.lo, 32'd42);

        issue(3'd6, 32'hFFFF, 32'd1);
        check("op6 busy", 32'(mdif.busy), 32'd0);
        check("op6 hi", mdif.hi, 32'hABCD);
        check("op6 lo", mdif.lo, 32'd42);

        // Asynchronous reset during DIV busy cycle 4.
        issue(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        check("pre_reset busy", 32'(mdif.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async busy", 32'(mdif.busy), 32'd0);
        check("async hi", mdif.hi, 32'd0);
        check("async lo", mdif.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset busy", 32'(mdif.busy), 32'd0);
        check("post_reset lo", mdif.lo, 32'd0);

        run_md("mult_after_reset", 3'd0, 32'h7FFF_FFFF, 32'd2, 5, 32'd0, 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
